// File: rtl/cpu_core_p_pkg.sv
// cpu_core_p shared package: opcodes, FSM states, register indices, defaults.
// No ports; imported by the core, its ALU and the data-bus interface users.
package cpu_core_p_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_ADC = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_IN  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  typedef enum logic {
    ALU_ADD,
    ALU_ADC
  } alu_op_e;

  localparam logic [3:0] R_A  = 4'd0;
  localparam logic [3:0] R_B  = 4'd1;
  localparam logic [3:0] R_C  = 4'd2;
  localparam logic [3:0] R_D  = 4'd3;
  localparam logic [3:0] R_SL = 4'd4;
  localparam logic [3:0] R_SH = 4'd5;
  localparam logic [3:0] R_PL = 4'd6;
  localparam logic [3:0] R_PH = 4'd7;
  localparam logic [3:0] R_R0 = 4'd8;
  localparam logic [3:0] R_R1 = 4'd9;
  localparam logic [3:0] R_R2 = 4'd10;
  localparam logic [3:0] R_R3 = 4'd11;
  localparam logic [3:0] R_R4 = 4'd12;
  localparam logic [3:0] R_R5 = 4'd13;
  localparam logic [3:0] R_R6 = 4'd14;
  localparam logic [3:0] R_R7 = 4'd15;

endpackage

// File: rtl/cpu_core_p_if.sv
// Data-memory bus of cpu_core_p: request (en/rw/addr/wdata) and reply (rdata/ready).
// master = core side, slave = memory side.
interface cpu_core_p_if #(
  parameter int DW = 4,
  parameter int AW = 8
);
  logic          ram_en;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ready;

  modport master (
    output ram_en, ram_rw, ram_addr, ram_wdata,
    input  ram_rdata, ram_ready
  );

  modport slave (
    input  ram_en, ram_rw, ram_addr, ram_wdata,
    output ram_rdata, ram_ready
  );
endinterface

// File: rtl/cpu_alu_p.sv
// cpu_alu_p: combinational adder for ADD/ADC.
// Ports: a_i, b_i, c_i (carry in), op_i in; y_o (result), c_o (carry), z_o (zero) out.
module cpu_alu_p
  import cpu_core_p_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          c_i,
  input  alu_op_e       op_i,
  output logic [DW-1:0] y_o,
  output logic          c_o,
  output logic          z_o
);
  logic          cin;
  logic [DW:0]   sum;

  always_comb begin
    cin = (op_i == ALU_ADC) & c_i;
    sum = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, cin};
    y_o = sum[DW-1:0];
    c_o = sum[DW];
    z_o = (sum[DW-1:0] == '0);
  end
endmodule

// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle 12-bit-instruction core (FETCH/EXEC/MEM/HALT).
// Ports: clk, rst_n, instr_addr/instr_bus (program), ram (data bus master), halted.
module cpu_core_p
  import cpu_core_p_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] instr_addr,
  input  logic [11:0]   instr_bus,
  cpu_core_p_if.master  ram,
  output logic          halted
);
  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [11:0]   ir_q;
  logic          cf_q;
  logic          zf_q;
  logic [DW-1:0] rf_q [16];
  logic          en_q;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          halted_q;

  logic [3:0]    op;
  logic [3:0]    fx;
  logic [3:0]    fy;
  logic [AW-1:0] tgt;
  logic [AW-1:0] pc_inc;
  alu_op_e       alu_op;
  logic [DW-1:0] alu_y;
  logic          alu_c;
  logic          alu_z;

  assign op     = ir_q[11:8];
  assign fx     = ir_q[7:4];
  assign fy     = ir_q[3:0];
  assign tgt    = ir_q[7:0];
  assign pc_inc = pc_q + {{(AW-1){1'b0}}, 1'b1};
  assign alu_op = (op == OP_ADC) ? ALU_ADC : ALU_ADD;

  cpu_alu_p #(.DW(DW)) u_alu (
    .a_i  (rf_q[R_A]),
    .b_i  (rf_q[R_B]),
    .c_i  (cf_q),
    .op_i (alu_op),
    .y_o  (alu_y),
    .c_o  (alu_c),
    .z_o  (alu_z)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      en_q     <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          ir_q    <= instr_bus;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          pc_q    <= pc_inc;
          case (op)
            OP_ADD, OP_ADC: begin
              rf_q[R_A] <= alu_y;
              cf_q      <= alu_c;
              zf_q      <= alu_z;
            end
            OP_MOV: rf_q[fx] <= rf_q[fy];
            OP_LDI: rf_q[R_B] <= DW'(fx);
            OP_IN, OP_OUT: begin
              // PC advances only once the memory replies
              state_q <= S_MEM;
              pc_q    <= pc_q;
              en_q    <= 1'b1;
              rw_q    <= (op == OP_OUT);
              addr_q  <= tgt;
              wdata_q <= rf_q[R_C];
            end
            OP_JMP: pc_q <= tgt;
            OP_JZ: begin
              if (zf_q) pc_q <= tgt;
            end
            OP_HLT: begin
              state_q  <= S_HALT;
              pc_q     <= pc_q;
              halted_q <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (ram.ram_ready) begin
            en_q    <= 1'b0;
            pc_q    <= pc_inc;
            state_q <= S_FETCH;
            if (!rw_q) rf_q[R_D] <= ram.ram_rdata;
          end
        end
        S_HALT: ;
      endcase
    end
  end

  assign instr_addr    = pc_q;
  assign ram.ram_en    = en_q;
  assign ram.ram_rw    = rw_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign halted        = halted_q;
endmodule
